qspi_master_arbiter: RTL and testbench

Quad-SPI bus master that shares one 4-bit QSPI link among NUM_REQ on-chip requesters and NUM_SLV quad slaves. It runs round-robin arbitration, drives the per-slave chip selects, generates the serial clock with CPOL=0, and moves one 8-bit full-duplex byte per transaction. Data moves as two nibbles, low nibble first. The block is the counterpart of the team's quad SPI slave: it drives MOSI on each rising qspi_clk edge and samples MISO on each falling edge.

---
 rtl/qspi_pkg.sv | 22 ++
 rtl/qspi_rr_arbiter.sv | 48 ++++
 rtl/qspi_master_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_qspi_master_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and widths for the quad-SPI master and its arbiter.
package qspi_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        H0,
        L0,
        H1,
        L1
    } phase_t;

endpackage

// File: rtl/qspi_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// starting the search at an internal pointer that advances past the served index.
module qspi_rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic          upd_i,
    input  logic [IW-1:0] upd_idx_i,
    output logic [N-1:0]  gnt_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // Outer loop walks priority order from the pointer; inner loop keeps indices constant.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (en_i && !found && req_i[j] && (j == (32'(ptr_q) + k) % N)) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = (upd_idx_i == IW'(N - 1)) ? '0 : upd_idx_i + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/qspi_master_arbiter.sv
// Quad-SPI master shared by NUM_REQ requesters: one full-duplex byte per
// transaction, low nibble first, MOSI launched on qspi_clk rise, MISO sampled on fall.
module qspi_master_arbiter
    import qspi_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = 2,
    parameter  int unsigned NUM_SLV  = 4,
    parameter  int unsigned CLK_DIV  = 2,
    parameter  int unsigned CS_SETUP = 1,
    parameter  int unsigned CS_HOLD  = 1,
    localparam int unsigned SW       = $clog2(NUM_SLV + 1),
    localparam int unsigned IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      sclk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*SW-1:0]     req_slave,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [BYTE_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      qspi_clk,
    output logic [NUM_SLV-1:0]        cs_n,
    output logic [NIBBLE_W-1:0]       mosi,
    input  logic [NIBBLE_W-1:0]       miso
);

    localparam int unsigned DW   = $clog2(CLK_DIV + 1);
    localparam int unsigned TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] SETUP_INIT = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_INIT  = TW'(CS_HOLD - 1);
    localparam logic [SW-1:0] SLV_LIM    = SW'(NUM_SLV);

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [DW-1:0]        div_q, div_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [SW-1:0]        slave_q, slave_d;
    logic [BYTE_W-1:0]    data_q, data_d;
    logic [BYTE_W-1:0]    rx_q, rx_d;

    logic [NUM_SLV-1:0]   cs_n_q, cs_n_d;
    logic                 qclk_q, qclk_d;
    logic [NIBBLE_W-1:0]  mosi_q, mosi_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [BYTE_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic [SW-1:0]        gnt_slave;
    logic [BYTE_W-1:0]    gnt_data;
    logic                 sel_active;

    qspi_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk_i     (sclk),
        .rst_i     (reset),
        .req_i     (req_valid),
        .en_i      (state_q == IDLE),
        .upd_i     (state_q == DONE),
        .upd_idx_i (idx_q),
        .gnt_o     (gnt)
    );

    assign req_ready = gnt & ~{NUM_REQ{reset}};

    always_comb begin
        gnt_idx   = '0;
        gnt_slave = '0;
        gnt_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx   = IW'(i);
                gnt_slave = req_slave[i*SW +: SW];
                gnt_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        div_d   = div_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        slave_d = slave_q;
        data_d  = data_q;
        rx_d    = rx_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    idx_d   = gnt_idx;
                    slave_d = gnt_slave;
                    data_d  = gnt_data;
                    rx_d    = '0;
                    tmr_d   = SETUP_INIT;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tmr_q == '0) begin
                    state_d = XFER;
                    phase_d = H0;
                    div_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            XFER: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    // The H->L edge is where the slave's nibble is captured.
                    unique case (phase_q)
                        H0: begin
                            phase_d                = L0;
                            rx_d[NIBBLE_W-1:0]     = miso;
                        end
                        L0: phase_d = H1;
                        H1: begin
                            phase_d                = L1;
                            rx_d[BYTE_W-1:NIBBLE_W] = miso;
                        end
                        L1: begin
                            state_d = HOLD;
                            tmr_d   = HOLD_INIT;
                        end
                    endcase
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (tmr_q == '0) begin
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are decoded from next state and registered, so they line up with the state.
    always_comb begin
        sel_active = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
        cs_n_d     = '1;
        for (int unsigned s = 0; s < NUM_SLV; s++) begin
            if (sel_active && (slave_d == SW'(s))) begin
                cs_n_d[s] = 1'b0;
            end
        end
        qclk_d = (state_d == XFER) && ((phase_d == H0) || (phase_d == H1));
        mosi_d = '0;
        case (state_d)
            SETUP: mosi_d = data_d[NIBBLE_W-1:0];
            XFER:  mosi_d = ((phase_d == H0) || (phase_d == L0)) ? data_d[NIBBLE_W-1:0]
                                                                  : data_d[BYTE_W-1:NIBBLE_W];
            HOLD:  mosi_d = data_d[BYTE_W-1:NIBBLE_W];
            default: mosi_d = '0;
        endcase
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        if (state_d == DONE) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (idx_d == IW'(i)) begin
                    rsp_valid_d[i] = 1'b1;
                end
            end
            rsp_err_d  = (slave_d >= SLV_LIM);
            rsp_data_d = rsp_err_d ? '0 : rx_d;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= H0;
            div_q       <= '0;
            tmr_q       <= '0;
            idx_q       <= '0;
            slave_q     <= '0;
            data_q      <= '0;
            rx_q        <= '0;
            cs_n_q      <= '1;
            qclk_q      <= 1'b0;
            mosi_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            slave_q     <= slave_d;
            data_q      <= data_d;
            rx_q        <= rx_d;
            cs_n_q      <= cs_n_d;
            qclk_q      <= qclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign qspi_clk  = qclk_q;
    assign mosi      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_qspi_master_arbiter.sv
// Bench for qspi_master_arbiter: cycle-level reference model of the transaction
// timeline, round-robin order and slave response, with two parameterisations.
`timescale 1ns/1ps
module tb_qspi_master_arbiter;

    typedef struct {
        int         slave;
        logic [7:0] data;
        logic [7:0] resp;
    } txn_t;

    logic        sclk      = 1'b0;
    logic        reset     = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [5:0]  req_slave = '0;
    logic [15:0] req_data  = '0;
    logic        sel       = 1'b0;

    logic [1:0] rdy_a, rv_a, rdy_b, rv_b;
    logic [7:0] rd_a, rd_b;
    logic       re_a, busy_a, qclk_a, re_b, busy_b, qclk_b;
    logic [3:0] cs_a, mosi_a, cs_b, mosi_b;
    logic [3:0] miso_a = '0, miso_b = '0;
    logic       half_a = 1'b0, half_b = 1'b0;
    logic [7:0] cur_resp = '0;

    logic [1:0] o_rdy, o_rv;
    logic [7:0] o_rd;
    logic       o_re, o_busy, o_qclk;
    logic [3:0] o_cs, o_mosi;

    always #5 sclk = ~sclk;

    qspi_master_arbiter #(.NUM_REQ(2), .NUM_SLV(4), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_a (
        .sclk(sclk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a),
        .req_slave(req_slave), .req_data(req_data), .rsp_valid(rv_a), .rsp_data(rd_a),
        .rsp_err(re_a), .busy(busy_a), .qspi_clk(qclk_a), .cs_n(cs_a), .mosi(mosi_a), .miso(miso_a)
    );

    qspi_master_arbiter #(.NUM_REQ(2), .NUM_SLV(4), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(3)) dut_b (
        .sclk(sclk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b),
        .req_slave(req_slave), .req_data(req_data), .rsp_valid(rv_b), .rsp_data(rd_b),
        .rsp_err(re_b), .busy(busy_b), .qspi_clk(qclk_b), .cs_n(cs_b), .mosi(mosi_b), .miso(miso_b)
    );

    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_rv   = sel ? rv_b   : rv_a;
    assign o_rd   = sel ? rd_b   : rd_a;
    assign o_re   = sel ? re_b   : re_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_qclk = sel ? qclk_b : qclk_a;
    assign o_cs   = sel ? cs_b   : cs_a;
    assign o_mosi = sel ? mosi_b : mosi_a;

    // Slave side: a quad slave launches its next nibble on each qspi_clk rise.
    always @(posedge qclk_a or posedge reset) begin
        if (reset) begin
            half_a = 1'b0;
            miso_a = '0;
        end else begin
            miso_a = half_a ? cur_resp[7:4] : cur_resp[3:0];
            half_a = ~half_a;
        end
    end

    always @(posedge qclk_b or posedge reset) begin
        if (reset) begin
            half_b = 1'b0;
            miso_b = '0;
        end else begin
            miso_b = half_b ? cur_resp[7:4] : cur_resp[3:0];
            half_b = ~half_b;
        end
    end

    int   total = 0, bad = 0;
    int   D = 2, S = 1, H = 1, LAT = 11;
    int   cyc = 0, ptr = 0, t_g = 0, g_idx = 0, g_slave = 0;
    bit   act = 1'b0;
    logic [7:0] g_data = '0, g_resp = '0;
    txn_t q0[$], q1[$];
    txn_t pulse_t;
    int   pulse_i = -1;
    int   dut_log[$];
    int   gnt_cyc = 0, rsp_cyc = 0, qrise = 0;
    logic prev_qclk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic push(input int i, input int s, input logic [7:0] d, input logic [7:0] r);
        txn_t t;
        t.slave = s;
        t.data  = d;
        t.resp  = r;
        if (i == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    function automatic int pick(input logic [1:0] rv, input int p);
        int j;
        for (int k = 0; k < 2; k++) begin
            j = (p + k) % 2;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    task automatic step();
        int o, x, pi, g;
        bit was_act;
        logic [3:0] ecs;
        logic [1:0] erv, erdy;
        logic eq, eb;
        txn_t t;
        @(posedge sclk);
        #1;
        cyc++;
        if (o_qclk === 1'b1 && prev_qclk === 1'b0) qrise++;
        prev_qclk = o_qclk;
        if (o_rv !== 2'b00) rsp_cyc = cyc;
        ecs = 4'hF;
        eq  = 1'b0;
        eb  = 1'b0;
        erv = '0;
        was_act = act;
        if (act) begin
            o  = cyc - t_g;
            eb = (o >= 1 && o <= LAT);
            if (o >= 1 && o <= LAT - 1 && g_slave < 4) ecs[g_slave] = 1'b0;
            if (o >= 1 && o <= S) begin
                chk("mosi_setup", 32'(o_mosi), 32'(g_data[3:0]));
            end else if (o > S && o <= S + 4 * D) begin
                x  = o - 1 - S;
                eq = ((x / D) % 2 == 0);
                chk("mosi_xfer", 32'(o_mosi), (x < 2 * D) ? 32'(g_data[3:0]) : 32'(g_data[7:4]));
            end
            if (o == LAT) begin
                erv[g_idx] = 1'b1;
                chk("rsp_data", 32'(o_rd), (g_slave < 4) ? 32'(g_resp) : 32'h0);
                chk("rsp_err", 32'(o_re), (g_slave < 4) ? 32'h0 : 32'h1);
                act = 1'b0;
                ptr = (g_idx + 1) % 2;
            end
        end
        chk("cs_n", 32'(o_cs), 32'(ecs));
        chk("qspi_clk", 32'(o_qclk), 32'(eq));
        chk("rsp_valid", 32'(o_rv), 32'(erv));
        chk("busy", 32'(o_busy), 32'(eb));
        pi = pulse_i;
        pulse_i = -1;
        for (int i = 0; i < 2; i++) begin
            if (pi == i) begin
                req_valid[i]       = 1'b1;
                req_slave[i*3 +: 3] = 3'(pulse_t.slave);
                req_data[i*8 +: 8]  = pulse_t.data;
            end else if (qsize(i) > 0) begin
                t = qfront(i);
                req_valid[i]       = 1'b1;
                req_slave[i*3 +: 3] = 3'(t.slave);
                req_data[i*8 +: 8]  = t.data;
            end else begin
                req_valid[i]       = 1'b0;
                req_slave[i*3 +: 3] = 3'($urandom);
                req_data[i*8 +: 8]  = 8'($urandom);
            end
        end
        #2;
        erdy = '0;
        g    = -1;
        if (!was_act) begin
            g = pick(req_valid, ptr);
            if (g >= 0) erdy[g] = 1'b1;
        end
        chk("req_ready", 32'(o_rdy), 32'(erdy));
        if (o_rdy === 2'b01) begin dut_log.push_back(0); gnt_cyc = cyc; end
        else if (o_rdy === 2'b10) begin dut_log.push_back(1); gnt_cyc = cyc; end
        if (g >= 0) begin
            if (g == pi) begin
                t = pulse_t;
            end else begin
                t = qfront(g);
                qpop(g);
            end
            g_idx    = g;
            g_slave  = t.slave;
            g_data   = t.data;
            g_resp   = t.resp;
            cur_resp = t.resp;
            act      = 1'b1;
            t_g      = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        for (int k = 0; k < 600; k++) begin
            if (!act && q0.size() == 0 && q1.size() == 0) break;
            step();
        end
        run(2);
    endtask

    task automatic do_reset();
        req_valid = 2'b11;
        reset = 1'b1;
        #1;
        chk("rst_cs_n", 32'(o_cs), 32'hF);
        chk("rst_qspi_clk", 32'(o_qclk), 32'h0);
        chk("rst_mosi", 32'(o_mosi), 32'h0);
        chk("rst_req_ready", 32'(o_rdy), 32'h0);
        chk("rst_rsp_valid", 32'(o_rv), 32'h0);
        chk("rst_rsp_data", 32'(o_rd), 32'h0);
        chk("rst_rsp_err", 32'(o_re), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_hold_rsp_valid", 32'(o_rv), 32'h0);
        @(negedge sclk);
        req_valid = '0;
        reset     = 1'b0;
        act       = 1'b0;
        ptr       = 0;
        pulse_i   = -1;
        prev_qclk = 1'b0;
        q0.delete();
        q1.delete();
        dut_log.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2;
        int exp_order [4] = '{0, 1, 0, 1};

        #2;
        do_reset();

        // Directed single transfer, slave 2.
        push(0, 2, 8'hA5, 8'h3C);
        run(14);
        chk("t1_grants", 32'(dut_log.size()), 32'd1);
        chk("t1_latency", 32'(rsp_cyc - gnt_cyc), 32'd11);

        // Both requesters contend from reset.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push(0, $urandom_range(0, 3), 8'($urandom), 8'($urandom));
            push(1, $urandom_range(0, 3), 8'($urandom), 8'($urandom));
        end
        run(4 * 12 + 4);
        chk("t2_grants", 32'(dut_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < dut_log.size()) chk("t2_order", 32'(dut_log[k]), 32'(exp_order[k]));
        end

        // Out-of-range target.
        qrise = 0;
        push(1, 4, 8'($urandom), 8'($urandom));
        run(14);
        chk("t3_qclk_pulses", 32'(qrise), 32'd2);

        // Reset landing in H1 aborts the transfer.
        push(0, 1, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 40; k++) begin
            if (act && (cyc - t_g) == 1 + S + 2 * D) break;
            step();
        end
        chk("t4_in_h1", 32'(o_qclk), 32'h1);
        do_reset();
        run(14);
        push(0, 3, 8'($urandom), 8'($urandom));
        run(14);
        chk("t4_retry_grants", 32'(dut_log.size()), 32'd1);

        // One-cycle request while busy is never served.
        push(0, 0, 8'($urandom), 8'($urandom));
        run(3);
        n1 = dut_log.size();
        pulse_t.slave = 1;
        pulse_t.data  = 8'h77;
        pulse_t.resp  = 8'h11;
        pulse_i = 1;
        run(24);
        n2 = dut_log.size();
        chk("t6_no_spurious_grant", 32'(n2 - n1), 32'd0);

        // Randomised traffic, slaves 0..4.
        for (int k = 0; k < 240; k++) begin
            if ($urandom_range(0, 7) == 0)
                push($urandom_range(0, 1), $urandom_range(0, 4), 8'($urandom), 8'($urandom));
            step();
        end
        drain();

        // Second parameterisation: CLK_DIV=1, CS_SETUP=2, CS_HOLD=3.
        sel = 1'b1;
        D = 1; S = 2; H = 3; LAT = 1 + S + 4 * D + H;
        do_reset();
        push(0, 1, 8'h0F, 8'hF0);
        run(13);
        chk("t5_latency", 32'(rsp_cyc - gnt_cyc), 32'd10);
        for (int k = 0; k < 8; k++)
            push($urandom_range(0, 1), $urandom_range(0, 4), 8'($urandom), 8'($urandom));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
